// File: rtl/alu_mul_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier that uses the shared
// combinational ALU as its adder; each STEP cycle adds one partial product.
module alu_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        out_zero,
    output logic        out_ovf,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_y,
    input  logic        alu_carry
);

    localparam logic [2:0] ALU_ADD = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [3:0]  cnt_q, cnt_d;

    // The 9-bit ALU sum shifts right into {hi,lo}, so the carry becomes the
    // new hi MSB and the consumed multiplier bit drops out of lo.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = in_a;
                    lo_d    = in_b;
                    hi_d    = 8'h00;
                    cnt_d   = 4'd0;
                    state_d = STEP;
                end
            end
            STEP: begin
                hi_d  = {alu_carry, alu_y[7:1]};
                lo_d  = {alu_y[0], lo_q[7:1]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= 8'h00;
            hi_q    <= 8'h00;
            lo_q    <= 8'h00;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake flags decode the registered state only, never in_valid.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    assign out_p    = {hi_q, lo_q};
    assign out_zero = ({hi_q, lo_q} == 16'h0000);
    assign out_ovf  = (hi_q != 8'h00);

    assign alu_op = ALU_ADD;
    assign alu_a  = (state_q == STEP) ? hi_q : 8'h00;
    assign alu_b  = ((state_q == STEP) && lo_q[0]) ? mcand_q : 8'h00;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural ADD-only ALU model.
module tb_alu_mul_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        out_zero;
    logic        out_ovf;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_y;
    logic        alu_carry;

    int checks;
    int failures;
    int cyc;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] expP;
        logic        expZero;
        logic        expOvf;
    } vec_t;

    vec_t vecs[8];

    alu_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .alu_carry (alu_carry)
    );

    // Shared ALU model: only ADD matters to this block.
    always_comb begin
        {alu_carry, alu_y} = 9'd0;
        case (alu_op)
            3'b000:  {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  {alu_carry, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
            default: {alu_carry, alu_y} = 9'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
    endtask

    // Runs from the cycle after an accept edge until out_valid, bounded.
    task automatic waitValid(output int cycles, output logic opOk, output logic bZero, output logic excl);
        cycles = 0;
        opOk   = 1'b1;
        bZero  = 1'b1;
        excl   = 1'b1;
        while (!out_valid && cycles < 30) begin
            if (alu_op !== 3'b000) opOk = 1'b0;
            if (alu_b !== 8'h00) bZero = 1'b0;
            if (in_ready && out_valid) excl = 1'b0;
            tick;
            cycles++;
        end
        if (alu_op !== 3'b000) opOk = 1'b0;
    endtask

    task automatic runOp(input vec_t v, input string name);
        int   cycles;
        logic opOk, bZero, excl;
        checkOutput({name, "_ready_before"}, {31'd0, in_ready}, 32'd1);
        applyStimulus(v.a, v.b);
        out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        in_a     = ~v.a;
        in_b     = ~v.b;
        waitValid(cycles, opOk, bZero, excl);
        checkOutput({name, "_latency"}, cycles, 32'd8);
        checkOutput({name, "_aluop"}, {31'd0, opOk}, 32'd1);
        checkOutput({name, "_excl"}, {31'd0, excl}, 32'd1);
        checkOutput({name, "_p"}, {16'd0, out_p}, {16'd0, v.expP});
        checkOutput({name, "_zero"}, {31'd0, out_zero}, {31'd0, v.expZero});
        checkOutput({name, "_ovf"}, {31'd0, out_ovf}, {31'd0, v.expOvf});
        checkOutput({name, "_ready_in_done"}, {31'd0, in_ready}, 32'd0);
        if (v.b == 8'h00) begin
            checkOutput({name, "_alub_zero"}, {31'd0, bZero}, 32'd1);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checkOutput({name, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        int          cycles;
        logic        opOk, bZero, excl, stableOk, busyOk, staleOk;
        logic [7:0]  bbA[4];
        logic [7:0]  bbB[4];
        int          accT[4];
        int          nAcc, nRes, budget;
        logic        prevReady, prevValid;
        logic [15:0] prevP;

        checks   = 0;
        failures = 0;
        cyc      = 0;
        in_valid = 1'b0;
        in_a     = 8'h00;
        in_b     = 8'h00;
        out_ready = 1'b0;

        vecs[0] = '{8'd13,  8'd11,  16'h008F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF,  8'hFF,  16'hFE01, 1'b0, 1'b1};
        vecs[2] = '{8'h00,  8'hA5,  16'h0000, 1'b1, 1'b0};
        vecs[3] = '{8'h5A,  8'h00,  16'h0000, 1'b1, 1'b0};
        vecs[4] = '{8'd7,   8'd9,   16'h003F, 1'b0, 1'b0};
        vecs[5] = '{8'h01,  8'h01,  16'h0001, 1'b0, 1'b0};
        vecs[6] = '{8'h80,  8'h02,  16'h0100, 1'b0, 1'b1};
        vecs[7] = '{8'h0F,  8'h11,  16'h00FF, 1'b0, 1'b0};

        rst = 1'b1;
        #12;
        checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_p", {16'd0, out_p}, 32'd0);
        checkOutput("reset_flags", {30'd0, out_zero, out_ovf}, 32'd2);
        checkOutput("reset_alu", {13'd0, alu_op, alu_a, alu_b}, 32'd0);
        #4;
        rst = 1'b0;
        tick;

        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE while a new command waits on in_valid.
        applyStimulus(8'd16, 8'd16);
        tick;
        applyStimulus(8'd3, 8'd5);
        waitValid(cycles, opOk, bZero, excl);
        checkOutput("bp_latency", cycles, 32'd8);
        stableOk = 1'b1;
        busyOk   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_p !== 16'h0100 || out_ovf !== 1'b1 || out_valid !== 1'b1) stableOk = 1'b0;
            if (in_ready !== 1'b0) busyOk = 1'b0;
            tick;
        end
        checkOutput("bp_stable", {31'd0, stableOk}, 32'd1);
        checkOutput("bp_no_accept", {31'd0, busyOk}, 32'd1);
        checkOutput("bp_p", {16'd0, out_p}, 32'h0100);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checkOutput("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);
        tick;
        in_valid = 1'b0;
        checkOutput("bp_next_accept", {31'd0, in_ready}, 32'd0);
        waitValid(cycles, opOk, bZero, excl);
        checkOutput("bp_next_latency", cycles, 32'd8);
        checkOutput("bp_next_p", {16'd0, out_p}, 32'd15);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // Reset in the 4th STEP cycle discards 200*3.
        applyStimulus(8'd200, 8'd3);
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        tick;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_p", {16'd0, out_p}, 32'd0);
        checkOutput("midrst_flags", {30'd0, out_zero, out_ovf}, 32'd2);
        checkOutput("midrst_alu", {13'd0, alu_op, alu_a, alu_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick;
        staleOk = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) staleOk = 1'b0;
            tick;
        end
        checkOutput("midrst_no_stale", {31'd0, staleOk}, 32'd1);
        runOp(vecs[4], "after_rst");

        // Back-to-back throughput against a multiply reference.
        bbA = '{8'd37, 8'd255, 8'd100, 8'd9};
        bbB = '{8'd91, 8'd2,   8'd100, 8'd250};
        nAcc = 0;
        nRes = 0;
        budget = 0;
        out_ready = 1'b1;
        applyStimulus(bbA[0], bbB[0]);
        while (nRes < 4 && budget < 100) begin
            prevReady = in_ready;
            prevValid = out_valid;
            prevP     = out_p;
            tick;
            budget++;
            if (prevReady && in_valid) begin
                accT[nAcc] = cyc;
                nAcc++;
                if (nAcc < 4) applyStimulus(bbA[nAcc], bbB[nAcc]);
                else in_valid = 1'b0;
            end
            if (prevValid) begin
                checkOutput($sformatf("b2b_p%0d", nRes), {16'd0, prevP},
                            {16'd0, 16'(bbA[nRes]) * 16'(bbB[nRes])});
                nRes++;
            end
        end
        out_ready = 1'b0;
        checkOutput("b2b_done", nRes, 32'd4);
        if (nAcc == 4) begin
            for (int i = 1; i < 4; i++) begin
                checkOutput($sformatf("b2b_gap%0d", i), accT[i] - accT[i-1], 32'd10);
            end
        end else begin
            checkOutput("b2b_accepts", nAcc, 32'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
